fpu_round_pipe: RTL and testbench
=================================

Name: fpu_round_pipe

Overview:
- Rounding and packing stage directly downstream of the double-precision multiplier.
- Consumes the multiplier's sign, 56-bit normalized mantissa term and 12-bit exponent term; applies the IEEE-754 rounding mode; produces the packed 64-bit double with exception flags.
- Two-stage pipeline with valid/ready handshake so the downstream writeback can stall it.

Parameters:
- MANT_W, 56, mantissa term width; only the default is supported.
- EXP_W, 12, exponent term width; only the default is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- sign  in  1  result sign.
- mantissa_term  in  56  [55]=0 headroom, [54]=hidden bit, [53:2]=fraction, [1]=guard, [0]=sticky.
- exponent_term  in  12  biased exponent; 0 means denormal.
- round_mode  in  2  00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out  out  64  packed double.
- overflow  out  1  result overflowed.
- underflow  out  1  result tiny and inexact.
- inexact  out  1  result inexact.

Behaviour:
- Reset: all stage valids, out_valid, out, overflow, underflow and inexact go to 0 immediately on rst, independent of clk. In-flight beats are discarded.
- Handshake:
  - stall = out_valid & !out_ready; in_ready = !stall (combinational).
  - A beat is accepted when in_valid & in_ready.
  - While stall is high, both stages hold their contents and out, flags and out_valid stay stable.
  - Bubbles are not collapsed.
- Latency: 2 cycles from acceptance to out_valid when never stalled. Throughput: 1 beat per cycle. Order preserved.
- Stage 1 (registered on acceptance):
  - m = mantissa_term[54:2]; g = mantissa_term[1]; s = mantissa_term[0]; lsb = m[0].
  - inc for mode 00 = g & (s | lsb).
  - inc for mode 01 = 0.
  - inc for mode 10 = (g | s) & !sign.
  - inc for mode 11 = (g | s) & sign.
  - sum[53:0] = {1'b0, m} + inc.
  - Also register sign, exponent_term, round_mode, and rx = g | s.
- Stage 2:
  - carry = sum[53]; denorm_up = (exponent_term == 0) & sum[52].
  - exp_f (13-bit) = exponent_term + carry + denorm_up.
  - frac = carry ? 52'b0 : sum[51:0].
  - Overflow when exp_f >= 2047 or exponent_term >= 2047. The result then depends on mode:
    - inf_sel = (mode == 00) | (mode == 10 & !sign) | (mode == 11 & sign).
    - inf_sel → {sign, 11'h7FF, 52'b0}.
    - Otherwise → {sign, 11'h7FE, 52'hF_FFFF_FFFF_FFFF} (max finite).
    - overflow = 1, inexact = 1.
  - Zero: m == 0 and no inc → {sign, 63'b0}, flags 0.
  - Normal case: out = {sign, exp_f[10:0], frac}.
    - inexact = rx.
    - underflow = (exp_f == 0) & rx.
- Simultaneous accept and output transfer in the same cycle is legal. Each beat is counted exactly once.
- round_mode and sign are sampled per beat; changing them mid-pipeline does not affect beats already accepted.

Optional Feature:
- Macro: FPU_ROUND_FLUSH_DENORM_EN.
- Defined:
  - Any result with exp_f == 0 and nonzero frac is replaced by {sign, 63'b0}.
  - underflow = 1 and inexact = 1 for such results.
  - denorm_up is still honoured, so a denormal rounding up to the minimum normal stays normal.
- Undefined: denormal results are output as computed above with gradual underflow.

Test Plan:
- 1.0×1.0: mantissa_term=56'h40000000000000, exponent_term=1023, mode 00 → out=64'h3FF0000000000000 after 2 cycles; all flags 0.
- Tie to even, then toward zero:
  - mantissa_term=56'h40000000000002, mode 00 → out=64'h3FF0000000000000, inexact=1.
  - mantissa_term=56'h40000000000006, mode 00 → out=64'h3FF0000000000002.
  - mantissa_term=56'h40000000000006, mode 01 → out=64'h3FF0000000000001.
- Carry-out: mantissa_term=56'h7FFFFFFFFFFFFE, exponent_term=1023, mode 00 → out=64'h4000000000000000, inexact=1.
- Overflow, sign=1, exponent_term=2047, mantissa_term=56'h40000000000000:
  - mode 10 → out=64'hFFEFFFFFFFFFFFFF, overflow=1.
  - mode 00 → out=64'hFFF0000000000000, overflow=1.
- Backpressure:
  - Hold out_ready=0 while offering 4 back-to-back beats → exactly 2 accepted, in_ready=0 afterwards, out stable.
  - Raise out_ready → all accepted beats emerge in order, none duplicated or lost.
- Reset mid-operation: assert rst asynchronously between clk edges with both stages valid → out_valid, out and flags are 0 before the next edge. After release, the first new beat appears 2 cycles after acceptance.

Source files
------------

// File: rtl/fpu_round_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fpu_round_pipe
// Purpose  : IEEE-754 double rounding/packing stage behind the multiplier.
//            Stage 1 applies the rounding increment, stage 2 handles carry,
//            denormal promotion, overflow, zero and packing. valid/ready
//            handshake lets the writeback stall the whole pipe.
// Options  : FPU_ROUND_FLUSH_DENORM_EN - flush denormal results to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_round_pipe #(
  parameter int MANT_W = 56,
  parameter int EXP_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign,
  input  logic [MANT_W-1:0] mantissa_term,
  input  logic [EXP_W-1:0]  exponent_term,
  input  logic [1:0]        round_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out,
  output logic              overflow,
  output logic              underflow,
  output logic              inexact
);

  localparam logic [1:0] c_RM_NEAREST = 2'b00;
  localparam logic [1:0] c_RM_ZERO    = 2'b01;
  localparam logic [1:0] c_RM_POS     = 2'b10;
  localparam logic [1:0] c_RM_NEG     = 2'b11;

  // Headroom bit is always zero from the multiplier; it carries no information.
  logic w_unused;
  assign w_unused = mantissa_term[MANT_W-1];

  logic w_stall;
  logic w_accept;
  assign w_stall   = out_valid & ~out_ready;
  assign in_ready  = ~w_stall;
  assign w_accept  = in_valid & in_ready;

  // ---------------- Stage 1: rounding increment ----------------
  logic [52:0] w_m;
  logic        w_g;
  logic        w_s;
  logic        w_inc;
  logic [53:0] w_sum_d;

  assign w_m = mantissa_term[54:2];
  assign w_g = mantissa_term[1];
  assign w_s = mantissa_term[0];

  // Select the increment for the beat's rounding mode.
  always_comb begin
    w_inc = 1'b0;
    case (round_mode)
      c_RM_NEAREST: w_inc = w_g & (w_s | w_m[0]);
      c_RM_ZERO:    w_inc = 1'b0;
      c_RM_POS:     w_inc = (w_g | w_s) & ~sign;
      c_RM_NEG:     w_inc = (w_g | w_s) & sign;
      default:      w_inc = 1'b0;
    endcase
  end

  assign w_sum_d = {1'b0, w_m} + {53'b0, w_inc};

  logic             v1_q;
  logic [53:0]      sum1_q;
  logic             sign1_q;
  logic [EXP_W-1:0] exp1_q;
  logic [1:0]       mode1_q;
  logic             rx1_q;

  // Stage-1 register: advances whenever the pipe is not stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      sum1_q  <= '0;
      sign1_q <= 1'b0;
      exp1_q  <= '0;
      mode1_q <= 2'b00;
      rx1_q   <= 1'b0;
    end else if (!w_stall) begin
      v1_q <= in_valid;
      if (w_accept) begin
        sum1_q  <= w_sum_d;
        sign1_q <= sign;
        exp1_q  <= exponent_term;
        mode1_q <= round_mode;
        rx1_q   <= w_g | w_s;
      end
    end
  end

  // ---------------- Stage 2: normalise, classify, pack ----------------
  logic        w_carry;
  logic        w_denorm_up;
  logic [12:0] w_exp_f;
  logic [51:0] w_frac;
  logic        w_ovf;
  logic        w_inf_sel;
  logic [63:0] w_out_d;
  logic        w_ovf_d;
  logic        w_unf_d;
  logic        w_inx_d;

  assign w_carry     = sum1_q[53];
  assign w_denorm_up = (exp1_q == '0) & sum1_q[52];
  assign w_exp_f     = {1'b0, exp1_q} + {12'b0, w_carry} + {12'b0, w_denorm_up};
  assign w_frac      = w_carry ? 52'b0 : sum1_q[51:0];
  assign w_ovf       = (w_exp_f >= 13'd2047) | (exp1_q >= 12'd2047);
  assign w_inf_sel   = (mode1_q == c_RM_NEAREST) |
                       ((mode1_q == c_RM_POS) & ~sign1_q) |
                       ((mode1_q == c_RM_NEG) & sign1_q);

  // Overflow takes priority over zero; sum of zero means m==0 with no increment.
  always_comb begin
    w_out_d = {sign1_q, w_exp_f[10:0], w_frac};
    w_ovf_d = 1'b0;
    w_unf_d = (w_exp_f == 13'd0) & rx1_q;
    w_inx_d = rx1_q;
    if (w_ovf) begin
      w_out_d = w_inf_sel ? {sign1_q, 11'h7FF, 52'b0}
                          : {sign1_q, 11'h7FE, 52'hF_FFFF_FFFF_FFFF};
      w_ovf_d = 1'b1;
      w_unf_d = 1'b0;
      w_inx_d = 1'b1;
    end else if (sum1_q == 54'd0) begin
      w_out_d = {sign1_q, 63'b0};
      w_unf_d = 1'b0;
      w_inx_d = 1'b0;
    end else begin
`ifdef FPU_ROUND_FLUSH_DENORM_EN
      if ((w_exp_f == 13'd0) && (w_frac != 52'd0)) begin
        w_out_d = {sign1_q, 63'b0};
        w_unf_d = 1'b1;
        w_inx_d = 1'b1;
      end
`endif
    end
  end

  logic        vout_q;
  logic [63:0] out_q;
  logic        ovf_q;
  logic        unf_q;
  logic        inx_q;

  // Output register: holds while stalled, otherwise takes stage 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vout_q <= 1'b0;
      out_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      inx_q  <= 1'b0;
    end else if (!w_stall) begin
      vout_q <= v1_q;
      if (v1_q) begin
        out_q <= w_out_d;
        ovf_q <= w_ovf_d;
        unf_q <= w_unf_d;
        inx_q <= w_inx_d;
      end
    end
  end

  assign out_valid = vout_q;
  assign out       = out_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inx_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_round_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_round_pipe
// Purpose  : Self-checking bench for fpu_round_pipe: directed vectors,
//            backpressure, randomized traffic against a value-level model,
//            asynchronous reset mid-flight.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_round_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign = 1'b0;
  logic [55:0] mantissa_term = '0;
  logic [11:0] exponent_term = '0;
  logic [1:0]  round_mode = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  int checks = 0;
  int errors = 0;

  fpu_round_pipe #(.MANT_W(56), .EXP_W(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign(sign), .mantissa_term(mantissa_term), .exponent_term(exponent_term),
    .round_mode(round_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  // Value-level reference: round the 53-bit significand by comparing the
  // discarded remainder against one half, then renormalise and classify.
  function automatic logic [66:0] ref_round(input logic sg, input logic [55:0] mt,
                                            input logic [11:0] e, input logic [1:0] md);
    logic [63:0] m, rnd, frac, res;
    logic [10:0] e11;
    int r, ef;
    bit up;
    logic ov, uf, ix;
    m = {11'b0, mt[54:2]};
    r = 2 * int'(mt[1]) + int'(mt[0]);
    case (md)
      2'd0:    up = (r > 2) || (r == 2 && m[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = (r != 0) && !sg;
      default: up = (r != 0) && sg;
    endcase
    rnd = m + (up ? 64'd1 : 64'd0);
    ef  = int'(e);
    ix  = (r != 0);
    uf  = 1'b0;
    ov  = 1'b0;
    if (rnd >= (64'd1 << 53)) begin
      ef   = ef + 1;
      frac = 64'd0;
    end else begin
      frac = rnd & ((64'd1 << 52) - 64'd1);
      if (e == 12'd0 && rnd >= (64'd1 << 52)) ef = ef + 1;
    end
    if (ef >= 2047 || int'(e) >= 2047) begin
      ov = 1'b1;
      ix = 1'b1;
      if (md == 2'd0 || (md == 2'd2 && !sg) || (md == 2'd3 && sg))
        res = {sg, 11'h7FF, 52'b0};
      else
        res = {sg, 11'h7FE, {52{1'b1}}};
    end else if (rnd == 64'd0) begin
      res = {sg, 63'b0};
      ix  = 1'b0;
    end else begin
      e11 = 11'(ef);
      res = {sg, e11, frac[51:0]};
      uf  = (ef == 0) && ix;
`ifdef FPU_ROUND_FLUSH_DENORM_EN
      if (ef == 0 && frac != 64'd0) begin
        res = {sg, 63'b0};
        uf  = 1'b1;
        ix  = 1'b1;
      end
`endif
    end
    return {res, ov, uf, ix};
  endfunction

  // Random beat with bias toward boundary exponents and mantissas.
  task automatic rand_beat();
    logic [63:0] rbits;
    int sel;
    rbits = {$urandom, $urandom};
    sign  = 1'(($urandom & 1));
    round_mode = 2'($urandom_range(0, 3));
    sel = $urandom_range(0, 9);
    case (sel)
      0: exponent_term = 12'd0;
      1: exponent_term = 12'd1;
      2: exponent_term = 12'd2046;
      3: exponent_term = 12'd2047;
      4: exponent_term = 12'($urandom);
      default: exponent_term = 12'($urandom_range(1, 2046));
    endcase
    sel = $urandom_range(0, 9);
    case (sel)
      0: mantissa_term = 56'h0;
      1: mantissa_term = 56'h7FFFFFFFFFFFFF;
      2: mantissa_term = {2'b00, rbits[53:0]};
      3: mantissa_term = {2'b01, {52{1'b1}}, rbits[1:0]};
      default: mantissa_term = {2'b01, rbits[53:0]};
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out !== 64'd0 || {overflow, underflow, inexact} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b out=%h flags=%b%b%b required 0/0/000",
               out_valid, out, overflow, underflow, inexact);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [55:0] t_m [13];
    logic [11:0] t_e [13];
    logic        t_s [13];
    logic [1:0]  t_md[13];
    logic [63:0] t_o [13];
    logic [2:0]  t_f [13];
    t_s[0]=0; t_m[0]=56'h40000000000000; t_e[0]=1023; t_md[0]=0; t_o[0]=64'h3FF0000000000000; t_f[0]=3'b000;
    t_s[1]=0; t_m[1]=56'h40000000000002; t_e[1]=1023; t_md[1]=0; t_o[1]=64'h3FF0000000000000; t_f[1]=3'b001;
    t_s[2]=0; t_m[2]=56'h40000000000006; t_e[2]=1023; t_md[2]=0; t_o[2]=64'h3FF0000000000002; t_f[2]=3'b001;
    t_s[3]=0; t_m[3]=56'h40000000000006; t_e[3]=1023; t_md[3]=1; t_o[3]=64'h3FF0000000000001; t_f[3]=3'b001;
    t_s[4]=0; t_m[4]=56'h7FFFFFFFFFFFFE; t_e[4]=1023; t_md[4]=0; t_o[4]=64'h4000000000000000; t_f[4]=3'b001;
    t_s[5]=1; t_m[5]=56'h40000000000000; t_e[5]=2047; t_md[5]=2; t_o[5]=64'hFFEFFFFFFFFFFFFF; t_f[5]=3'b101;
    t_s[6]=1; t_m[6]=56'h40000000000000; t_e[6]=2047; t_md[6]=0; t_o[6]=64'hFFF0000000000000; t_f[6]=3'b101;
    t_s[7]=0; t_m[7]=56'h40000000000000; t_e[7]=2047; t_md[7]=1; t_o[7]=64'h7FEFFFFFFFFFFFFF; t_f[7]=3'b101;
    t_s[8]=1; t_m[8]=56'h00000000000000; t_e[8]=5;    t_md[8]=0; t_o[8]=64'h8000000000000000; t_f[8]=3'b000;
    t_s[9]=1; t_m[9]=56'h40000000000002; t_e[9]=1023; t_md[9]=3; t_o[9]=64'hBFF0000000000001; t_f[9]=3'b001;
    t_s[10]=0; t_m[10]=56'h3FFFFFFFFFFFFE; t_e[10]=0; t_md[10]=0; t_o[10]=64'h0010000000000000; t_f[10]=3'b001;
`ifdef FPU_ROUND_FLUSH_DENORM_EN
    t_s[11]=0; t_m[11]=56'h00000000000004; t_e[11]=0; t_md[11]=0; t_o[11]=64'h0; t_f[11]=3'b011;
    t_s[12]=0; t_m[12]=56'h00000000000006; t_e[12]=0; t_md[12]=0; t_o[12]=64'h0; t_f[12]=3'b011;
`else
    t_s[11]=0; t_m[11]=56'h00000000000004; t_e[11]=0; t_md[11]=0; t_o[11]=64'h1; t_f[11]=3'b000;
    t_s[12]=0; t_m[12]=56'h00000000000006; t_e[12]=0; t_md[12]=0; t_o[12]=64'h2; t_f[12]=3'b011;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      sign = t_s[i]; mantissa_term = t_m[i]; exponent_term = t_e[i]; round_mode = t_md[i];
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_latency[%0d]: out_valid=%b one cycle after accept, required 0", i, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out !== t_o[i] || {overflow, underflow, inexact} !== t_f[i]) begin
        errors++;
        $display("FAIL directed[%0d]: valid=%b out=%h flags(o,u,i)=%b%b%b required 1 %h %b",
                 i, out_valid, out, overflow, underflow, inexact, t_o[i], t_f[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [66:0] q[$];
    logic [66:0] exp_v;
    logic [63:0] held;
    int acc = 0;
    int got = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_beat();
      in_valid = 1'b1;
      #1;
      if (in_ready) begin
        acc++;
        q.push_back(ref_round(sign, mantissa_term, exponent_term, round_mode));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (acc != 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept: accepted=%0d in_ready=%b out_valid=%b required 2/0/1",
               acc, in_ready, out_valid);
    end
    held = out;
    repeat (3) @(negedge clk);
    checks++;
    if (out !== held || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stable: out=%h valid=%b required %h 1", out, out_valid, held);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid && q.size() > 0) begin
        exp_v = q.pop_front();
        got++;
        checks++;
        if ({out, overflow, underflow, inexact} !== exp_v) begin
          errors++;
          $display("FAIL bp_drain[%0d]: got %h_%b%b%b required %h_%b",
                   got, out, overflow, underflow, inexact, exp_v[66:3], exp_v[2:0]);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (got != 2 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: drained=%0d out_valid=%b required 2 0", got, out_valid);
    end
  endtask

  task automatic test_random();
    logic [66:0] q[$];
    logic [66:0] exp_v;
    logic        prev_stall = 1'b0;
    logic [66:0] prev_o = '0;
    int idle = 0;
    for (int c = 0; c < 3000; c++) begin
      rand_beat();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || {out, overflow, underflow, inexact} !== prev_o) begin
          errors++;
          $display("FAIL rand_stall_hold: valid=%b out=%h required 1 %h", out_valid, out, prev_o[66:3]);
        end
      end
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++;
        $display("FAIL rand_in_ready: got %b required %b", in_ready, !(out_valid && !out_ready));
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious: out=%h with no beat pending, required none", out);
        end else begin
          exp_v = q.pop_front();
          if ({out, overflow, underflow, inexact} !== exp_v) begin
            errors++;
            $display("FAIL rand_data: got %h_%b%b%b required %h_%b",
                     out, overflow, underflow, inexact, exp_v[66:3], exp_v[2:0]);
          end
        end
      end
      if (in_valid && in_ready)
        q.push_back(ref_round(sign, mantissa_term, exponent_term, round_mode));
      prev_stall = out_valid && !out_ready;
      prev_o = {out, overflow, underflow, inexact};
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && idle < 20) begin
      #1;
      if (out_valid) begin
        exp_v = q.pop_front();
        checks++;
        if ({out, overflow, underflow, inexact} !== exp_v) begin
          errors++;
          $display("FAIL rand_drain: got %h_%b%b%b required %h_%b",
                   out, overflow, underflow, inexact, exp_v[66:3], exp_v[2:0]);
        end
      end
      idle++;
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rand_lost: %0d beats never emerged, required 0", q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    logic [66:0] exp_v;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_beat();
      mantissa_term = 56'h40000000000006;
      exponent_term = 12'd1000;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== 64'd0 || {overflow, underflow, inexact} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: valid=%b out=%h flags=%b%b%b required 0 0 000",
               out_valid, out, overflow, underflow, inexact);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: out_valid=%b after reset, required 0", out_valid);
    end
    rand_beat();
    in_valid = 1'b1;
    exp_v = ref_round(sign, mantissa_term, exponent_term, round_mode);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_latency: out_valid=%b early, required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || {out, overflow, underflow, inexact} !== exp_v) begin
      errors++;
      $display("FAIL post_reset_beat: valid=%b got %h_%b%b%b required 1 %h_%b",
               out_valid, out, overflow, underflow, inexact, exp_v[66:3], exp_v[2:0]);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
